// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, drives a 1-cycle synchronous
// instruction memory and presents {instr, pc, pc_plus4} to decode through a 2-entry queue.
module fetch_stage #(
    parameter int unsigned               DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]     RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_en,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  valid,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4
);

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned CRED_W = CNT_W + 1;
    localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MSK = ~DATA_WIDTH'(3);

    logic [DATA_WIDTH-1:0] fpc;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] inflight_pc;
    logic [DATA_WIDTH-1:0] q_instr [DEPTH];
    logic [DATA_WIDTH-1:0] q_pc    [DEPTH];
    logic [CNT_W-1:0]      count;

    logic                  pop;
    logic                  push;
    logic [CRED_W-1:0]     credit;
    logic [CNT_W-1:0]      occ_after_pop;
    logic [DATA_WIDTH-1:0] target;

    // Handshake, credit-based issue and head presentation.
    always_comb begin
        valid         = (count != '0) & ~redirect & ~rst;
        pop           = valid & ready;
        push          = inflight & ~redirect;
        occ_after_pop = count - CNT_W'(pop);
        credit        = CRED_W'(count) + CRED_W'(inflight) - CRED_W'(pop);
        imem_en       = ~rst & ~redirect & (credit < CRED_W'(DEPTH));
        imem_addr     = fpc;
        target        = redirect_pc & ALIGN_MSK;
        instr         = q_instr[0];
        pc            = q_pc[0];
        pc_plus4      = q_pc[0] + PC_STEP;
    end

    // Control state: fetch PC, in-flight tracking and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
        end else if (redirect) begin
            fpc      <= target;
            inflight <= 1'b0;
            count    <= '0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                fpc         <= fpc + PC_STEP;
                inflight_pc <= fpc;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue storage: slot 0 is the head; a push lands behind whatever survives the pop.
    always_ff @(posedge clk) begin
        if (!rst && !redirect) begin
            if (pop) begin
                q_instr[0] <= q_instr[1];
                q_pc[0]    <= q_pc[1];
            end
            if (push) begin
                if (occ_after_pop == '0) begin
                    q_instr[0] <= imem_rdata;
                    q_pc[0]    <= inflight_pc;
                end else begin
                    q_instr[1] <= imem_rdata;
                    q_pc[1]    <= inflight_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table and corner sequences, then random
// traffic checked against a transaction-level model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, redirect, ready;
    logic [31:0] redirect_pc;
    logic        imem_en, w_imem_en;
    logic [31:0] imem_addr, w_imem_addr;
    logic [31:0] imem_rdata, w_imem_rdata;
    logic        valid, w_valid;
    logic [31:0] instr, pc, pc_plus4, w_instr, w_pc, w_pc_plus4;

    logic scramble = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .valid(valid), .ready(ready), .instr(instr), .pc(pc), .pc_plus4(pc_plus4)
    );

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .valid(w_valid), .ready(ready), .instr(w_instr), .pc(w_pc), .pc_plus4(w_pc_plus4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (scramble) return {a[7:0], a[31:8]} ^ 32'h5A5A_A5A5;
        return a;
    endfunction

    // Synchronous instruction memories, one cycle of read latency.
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= mem_word(imem_addr);
        if (w_imem_en) w_imem_rdata <= mem_word(w_imem_addr);
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model: every issued address is delivered in order exactly two cycles after
    // issue at the earliest; a flush forgets everything outstanding.
    typedef struct {
        logic [31:0] a;
        int          c;
    } iss_t;
    iss_t        oq[$];
    logic [31:0] iss_next;

    logic        s_valid, s_en, s_wvalid, s_wen;
    logic [31:0] s_pc, s_instr, s_plus4, s_addr, s_wpc, s_wplus4, s_waddr;

    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        logic ev, een, pp;
        rst = r; redirect = rd; redirect_pc = rpc; ready = rdy;
        @(negedge clk);
        s_valid = valid;  s_pc = pc; s_instr = instr; s_plus4 = pc_plus4;
        s_en = imem_en;   s_addr = imem_addr;
        s_wvalid = w_valid; s_wpc = w_pc; s_wplus4 = w_pc_plus4;
        s_wen = w_imem_en;  s_waddr = w_imem_addr;
        if (r || rd) begin
            chk("flush_valid", 32'(valid), 32'd0);
            chk("flush_imem_en", 32'(imem_en), 32'd0);
            oq.delete();
            iss_next = r ? 32'h0 : {rpc[31:2], 2'b00};
        end else begin
            ev = (oq.size() != 0) && (oq[0].c <= cyc - 2);
            chk("model_valid", 32'(valid), 32'(ev));
            if (ev && valid) begin
                chk("model_pc", pc, oq[0].a);
                chk("model_instr", instr, mem_word(oq[0].a));
                chk("model_pc_plus4", pc_plus4, oq[0].a + 32'd4);
            end
            pp = ev && rdy;
            if (pp) void'(oq.pop_front());
            een = (oq.size() < 2);
            chk("model_imem_en", 32'(imem_en), 32'(een));
            if (een) begin
                chk("model_imem_addr", imem_addr, iss_next);
                oq.push_back('{a: iss_next, c: cyc});
                iss_next = iss_next + 32'd4;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic        een;
        logic [31:0] eaddr;
    } vec_t;
    vec_t tbl[23];

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                                input logic rdy, input logic ev, input logic [31:0] epc,
                                input logic een, input logic [31:0] eaddr);
        vec_t v;
        v.r = r; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.een = een; v.eaddr = eaddr;
        return v;
    endfunction

    initial begin
        // Reset release, streaming, back-pressure, redirect in flight, double redirect.
        tbl[0]  = mk(1, 0, 0,     1, 0, 0,     0, 0);
        tbl[1]  = mk(1, 0, 0,     1, 0, 0,     0, 0);
        tbl[2]  = mk(0, 0, 0,     1, 0, 0,     1, 32'h0);
        tbl[3]  = mk(0, 0, 0,     1, 0, 0,     1, 32'h4);
        tbl[4]  = mk(0, 0, 0,     1, 1, 32'h0, 1, 32'h8);
        tbl[5]  = mk(0, 0, 0,     1, 1, 32'h4, 1, 32'hC);
        for (int i = 6; i <= 10; i++) tbl[i] = mk(0, 0, 0, 0, 1, 32'h8, 0, 0);
        tbl[11] = mk(0, 0, 0,       1, 1, 32'h8,   1, 32'h10);
        tbl[12] = mk(0, 0, 0,       1, 1, 32'hC,   1, 32'h14);
        tbl[13] = mk(0, 1, 32'h103, 1, 0, 0,       0, 0);
        tbl[14] = mk(0, 0, 0,       1, 0, 0,       1, 32'h100);
        tbl[15] = mk(0, 0, 0,       1, 0, 0,       1, 32'h104);
        tbl[16] = mk(0, 0, 0,       1, 1, 32'h100, 1, 32'h108);
        tbl[17] = mk(0, 1, 32'h100, 1, 0, 0,       0, 0);
        tbl[18] = mk(0, 1, 32'h200, 1, 0, 0,       0, 0);
        tbl[19] = mk(0, 0, 0,       1, 0, 0,       1, 32'h200);
        tbl[20] = mk(0, 0, 0,       1, 0, 0,       1, 32'h204);
        tbl[21] = mk(0, 0, 0,       1, 1, 32'h200, 1, 32'h208);
        tbl[22] = mk(0, 0, 0,       1, 1, 32'h204, 1, 32'h20C);

        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
        iss_next = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].r, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
            chk("tbl_valid", 32'(s_valid), 32'(tbl[i].ev));
            chk("tbl_imem_en", 32'(s_en), 32'(tbl[i].een));
            if (tbl[i].ev) begin
                chk("tbl_pc", s_pc, tbl[i].epc);
                chk("tbl_instr", s_instr, tbl[i].epc);
                chk("tbl_pc_plus4", s_plus4, tbl[i].epc + 32'd4);
            end
            if (tbl[i].een) chk("tbl_imem_addr", s_addr, tbl[i].eaddr);
        end

        // PC wrap-around on the instance reset to 0xFFFF_FFF8.
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("wrap_en0", 32'(s_wen), 32'd1);
        chk("wrap_addr0", s_waddr, WRAP_PC);
        step(0, 0, 0, 1);
        chk("wrap_addr1", s_waddr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        chk("wrap_valid0", 32'(s_wvalid), 32'd1);
        chk("wrap_pc0", s_wpc, WRAP_PC);
        chk("wrap_plus4_0", s_wplus4, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        chk("wrap_pc1", s_wpc, 32'hFFFF_FFFC);
        chk("wrap_plus4_1", s_wplus4, 32'h0);
        step(0, 0, 0, 1);
        chk("wrap_pc2", s_wpc, 32'h0);
        chk("wrap_plus4_2", s_wplus4, 32'h4);

        // Reset with the queue occupied and a request outstanding.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("midrst_pre_valid", 32'(s_valid), 32'd1);
        chk("midrst_pre_en", 32'(s_en), 32'd0);
        step(1, 0, 0, 1);
        chk("midrst_valid", 32'(s_valid), 32'd0);
        step(0, 0, 0, 1);
        chk("midrst_after_valid", 32'(s_valid), 32'd0);
        chk("midrst_after_addr", s_addr, 32'h0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("midrst_first_pc", s_pc, 32'h0);
        step(0, 0, 0, 1);
        chk("midrst_second_pc", s_pc, 32'h4);

        // Random traffic against the model.
        scramble = 1'b1;
        step(1, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            logic        r, rd, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) < 2);
            rd  = ($urandom_range(0, 99) < 5);
            rdy = ($urandom_range(0, 99) < 70);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step(r, rd, rpc, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
